// File: rtl/xm23_display_pkg.sv
// Shared types and constants for the XM23 seven-segment display path.
package xm23_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // 10^n, valid while the result fits in 64 bits (n <= 19).
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adjust
  import xm23_display_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Iterative binary-to-BCD converter, one bit per clock, saturating at all nines.
module bin_to_bcd_serial
  import xm23_display_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [63:0] LIMIT64   = pow10(DIGITS);
  localparam int          LIM_W_RAW = $clog2(LIMIT64) + 1;
  localparam int          LIM_W     = (BIN_W > LIM_W_RAW) ? BIN_W : LIM_W_RAW;
  localparam logic [LIM_W-1:0] LIMIT = LIM_W'(LIMIT64);
  // A narrow input that can never reach 10^DIGITS never overflows.
  localparam bit CAN_OVF = (BIN_W >= 64) || ((64'd1 << BIN_W) > LIMIT64);

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  bcd_state_t         state_q, state_d;
  logic [WORK_W-1:0]  work_q;
  logic [WORK_W-1:0]  work_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [LIM_W-1:0]   bin_ext;
  logic               ovf_in;
  logic               unused_adj_msb;

  assign bin_ext        = LIM_W'(bin_in);
  assign ovf_in         = CAN_OVF && (bin_ext >= LIMIT);
  assign unused_adj_msb = work_adj[WORK_W-1];

  assign work_adj[BIN_W-1:0] = work_q[BIN_W-1:0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (work_q[BIN_W + 4*k +: 4]),
      .q (work_adj[BIN_W + 4*k +: 4])
    );
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_IT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy trails the state by one edge, so it covers exactly the shift edges.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      work_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_q == SHIFT);
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= {{BCD_W{1'b0}}, bin_in};
            ovf_q  <= ovf_in;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          work_q <= {work_adj[WORK_W-2:0], 1'b0};
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          bcd_out  <= ovf_q ? {DIGITS{BCD_NINE}} : work_q[WORK_W-1 -: BCD_W];
          overflow <= ovf_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Randomised self-checking bench for bin_to_bcd_serial against a decimal reference model.
module tb_bin_to_bcd_serial;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = BIN_W + 1;

  logic              clk = 1'b0;
  logic              init;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy, done, overflow;
  logic [4*DIGITS-1:0] bcd_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .init     (init),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

  function automatic logic ref_ovf(input longint unsigned v);
    return v >= 64'd100_000_000;
  endfunction

  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned x;
    if (ref_ovf(v)) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Issues one start pulse from IDLE and returns at the negedge where done is seen.
  task automatic run_conv(input logic [BIN_W-1:0] v, output int lat, output int busy_cnt,
                          output bit timed_out);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start    = 1'b0;
    bin_in   = BIN_W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat >= 100) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    init   = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_checks++; if (bcd_out !== 32'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
    init = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bc;
    bit to;
    run_conv('0, lat, bc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got no done expected done"); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (bc != BIN_W) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected %0d", bc, BIN_W); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_done: got %b expected 0", busy); end
    n_checks++; if (bcd_out !== 32'h0) begin n_fail++; $display("FAIL zero_bcd: got %h expected 0", bcd_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL zero_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done); end
  endtask

  task automatic test_values();
    logic [BIN_W-1:0] vals [5];
    int lat, bc;
    bit to;
    vals = '{27'd12_345_678, 27'd99_999_999, 27'd100_000_000, 27'd134_217_727, 27'd42};
    foreach (vals[i]) begin
      run_conv(vals[i], lat, bc, to);
      n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL val_latency[%0d]: got %0d expected %0d", vals[i], lat, LAT); end
      n_checks++; if (bcd_out !== ref_bcd(vals[i])) begin n_fail++; $display("FAIL val_bcd[%0d]: got %h expected %h", vals[i], bcd_out, ref_bcd(vals[i])); end
      n_checks++; if (overflow !== ref_ovf(vals[i])) begin n_fail++; $display("FAIL val_ovf[%0d]: got %b expected %b", vals[i], overflow, ref_ovf(vals[i])); end
    end
  endtask

  task automatic test_random();
    logic [BIN_W-1:0] v;
    int lat, bc;
    bit to;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       v = BIN_W'($urandom_range(0, 99_999_999));
        1:       v = BIN_W'($urandom_range(100_000_000, 134_217_727));
        default: v = BIN_W'($urandom_range(0, 9_999));
      endcase
      run_conv(v, lat, bc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout[%0d]: got no done expected done", v); end
      n_checks++; if (bcd_out !== ref_bcd(v) || overflow !== ref_ovf(v)) begin
        n_fail++; $display("FAIL rand_result[%0d]: got %h/%b expected %h/%b", v, bcd_out, overflow, ref_bcd(v), ref_ovf(v));
      end
    end
  endtask

  task automatic test_ignored_start();
    int n_done, done_lat, late_busy;
    logic [31:0] got;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 27'd1000;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 27'd555;
    n_done = 0; done_lat = -1; late_busy = 0; got = '0;
    for (int lat = 0; lat <= 70; lat++) begin
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin got = bcd_out; done_lat = lat; end
      end
      if (lat > LAT && busy === 1'b1) late_busy++;
      start = (lat == 5 || lat == 27);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", n_done); end
    n_checks++; if (done_lat != LAT) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", done_lat, LAT); end
    n_checks++; if (got !== 32'h0000_1000) begin n_fail++; $display("FAIL ign_bcd: got %h expected 00001000", got); end
    n_checks++; if (late_busy != 0) begin n_fail++; $display("FAIL ign_second_conv: got %0d busy cycles expected 0", late_busy); end
  endtask

  task automatic test_init_mid();
    int stray, lat, bc;
    bit to;
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'($urandom_range(1, 99_999_999));
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 init = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL init_done: got %b expected 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL init_ovf: got %b expected 0", overflow); end
    n_checks++; if (bcd_out !== 32'h0) begin n_fail++; $display("FAIL init_bcd: got %h expected 0", bcd_out); end
    @(negedge clk);
    init = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL init_discard: got %0d active cycles expected 0", stray); end
    run_conv(27'd7, lat, bc, to);
    n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL init_restart_lat: got %0d expected %0d", lat, LAT); end
    n_checks++; if (bcd_out !== 32'h0000_0007) begin n_fail++; $display("FAIL init_restart_bcd: got %h expected 00000007", bcd_out); end
  endtask

  task automatic test_back_to_back();
    longint unsigned base;
    int n_done, last, exp_e;
    base = $urandom_range(0, 99_000_000);
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(base);
    n_done = 0;
    last   = -1;
    for (int e = 0; e < 120; e++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        exp_e = (n_done == 0) ? LAT : last + LAT + 1;
        n_checks++; if (e != exp_e) begin n_fail++; $display("FAIL b2b_period: got edge %0d expected %0d", e, exp_e); end
        n_checks++; if (bcd_out !== ref_bcd(base + e - LAT)) begin
          n_fail++; $display("FAIL b2b_bcd: got %h expected %h", bcd_out, ref_bcd(base + e - LAT));
        end
        last = e;
        n_done++;
      end
      bin_in = BIN_W'(base + e + 1);
    end
    start = 1'b0;
    n_checks++; if (n_done != 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", n_done); end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_random();
    test_ignored_start();
    test_init_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
